// File: rtl/mult_rr_arbiter.sv
// Round-robin front end sharing one pipelined multiplier among requesters.
// A tag pipeline tracks the owner of each in-flight product.
module mult_rr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic [2*DATA_WIDTH-1:0]       mul_result,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic                          busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int D  = MULT_LATENCY + 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IW-1:0]         ptr;
  logic [IW-1:0]         gidx;
  logic                  gany;
  logic                  xfer;
  logic [IW:0]           srch;
  logic [DATA_WIDTH-1:0] win_a;
  logic [DATA_WIDTH-1:0] win_b;
  logic [D-1:0]          tag_v;
  logic [IW-1:0]         tag_idx [D];

  // Scan from ptr upward, wrapping at NUM_REQ; first valid wins.
  always_comb begin
    gany = 1'b0;
    gidx = '0;
    srch = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      srch = {1'b0, ptr} + (IW+1)'(k);
      if (srch >= (IW+1)'(NUM_REQ))
        srch = srch - (IW+1)'(NUM_REQ);
      if (!gany && req_valid[srch[IW-1:0]]) begin
        gany = 1'b1;
        gidx = srch[IW-1:0];
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        win_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        win_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer      = gany & ~rst;
  assign req_ready = xfer ? (ONE << gidx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      tag_v <= '0;
      for (int i = 0; i < D; i++)
        tag_idx[i] <= '0;
    end else begin
      if (xfer) begin
        ptr   <= (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
        mul_a <= win_a;
        mul_b <= win_b;
      end
      tag_v      <= {tag_v[D-2:0], xfer};
      tag_idx[0] <= gidx;
      for (int i = 1; i < D; i++)
        tag_idx[i] <= tag_idx[i-1];
    end
  end

  assign rsp_valid = tag_v[D-1] ? (ONE << tag_idx[D-1]) : '0;
  assign rsp_data  = tag_v[D-1] ? mul_result : '0;
  assign busy      = |tag_v;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Scoreboard bench for mult_rr_arbiter with a 3-stage multiplier model.
// Grant order, operands, busy and responses are all predicted locally.
module tb_mult_rr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [DW-1:0]     mul_a;
  logic [DW-1:0]     mul_b;
  logic [2*DW-1:0]   mul_result;
  logic [NR-1:0]     rsp_valid;
  logic [2*DW-1:0]   rsp_data;
  logic              busy;

  logic [DW-1:0]     a_v [NR];
  logic [DW-1:0]     b_v [NR];
  logic [2*DW-1:0]   mp [LAT];

  typedef struct {
    logic [NR-1:0]   oh;
    logic [2*DW-1:0] p;
    int              due;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc_n = 0;
  int            rsp_cnt = 0;
  int            mptr = 0;
  logic [DW-1:0] exp_ma = '0;
  logic [DW-1:0] exp_mb = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = a_v[i];
      req_b[i*DW +: DW] = b_v[i];
    end
  end

  always @(posedge clk) begin
    mp[0] <= {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
    for (int i = 1; i < LAT; i++)
      mp[i] <= mp[i-1];
  end
  assign mul_result = mp[LAT-1];

  mult_rr_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MULT_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic sample();
    exp_t          e;
    logic          bexp;
    logic [NR-1:0] rexp;
    int            w;
    @(negedge clk);
    bexp = 1'b0;
    foreach (q[i])
      if (q[i].due - (LAT+1) < cyc_n) bexp = 1'b1;
    check("busy", 64'(busy), 64'(bexp));
    check("mul_a", 64'(mul_a), 64'(exp_ma));
    check("mul_b", 64'(mul_b), 64'(exp_mb));
    if (rsp_valid != '0 || (q.size() > 0 && q[0].due == cyc_n)) begin
      if (q.size() == 0) begin
        check("rsp_unexp", 64'(rsp_valid), 64'(0));
      end else begin
        e = q.pop_front();
        check("rsp_cyc", 64'(cyc_n), 64'(e.due));
        check("rsp_own", 64'(rsp_valid), 64'(e.oh));
        check("rsp_data", rsp_data, e.p);
        rsp_cnt++;
      end
    end else begin
      check("rsp_idle", rsp_data, 64'(0));
    end
    rexp = '0;
    w = -1;
    if (!rst) begin
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && req_valid[(mptr + k) % NR]) w = (mptr + k) % NR;
      end
    end
    if (w >= 0) rexp[w] = 1'b1;
    check("ready", 64'(req_ready), 64'(rexp));
    if (w >= 0) begin
      e.oh  = rexp;
      e.p   = {{DW{1'b0}}, a_v[w]} * {{DW{1'b0}}, b_v[w]};
      e.due = cyc_n + LAT + 1;
      q.push_back(e);
      mptr   = (w + 1) % NR;
      exp_ma = a_v[w];
      exp_mb = b_v[w];
    end
    if (rst) begin
      q.delete();
      mptr   = 0;
      exp_ma = '0;
      exp_mb = '0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !busy) break;
      step();
    end
    check("drain", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int n0;
    for (int i = 0; i < NR; i++) begin
      a_v[i] = DW'(i + 2);
      b_v[i] = DW'(10 * i + 3);
    end
    adv();
    req_valid = '1;
    step();
    check("rst_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    req_valid = '0;
    sample();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp", 64'(rsp_valid), 64'(0));
    adv();

    // single request from requester 2
    n0 = rsp_cnt;
    a_v[2] = 7; b_v[2] = 6;
    req_valid = 4'b0100;
    sample();
    check("single_rdy", 64'(req_ready), 64'(4'b0100));
    adv();
    req_valid = '0;
    for (int i = 0; i < 3; i++) step();
    sample();
    check("single_rsp", 64'(rsp_valid), 64'(4'b0100));
    check("single_42", rsp_data, 64'd42);
    adv();
    drain();
    check("single_cnt", 64'(rsp_cnt - n0), 64'(1));

    // full contention with distinct operands
    for (int i = 0; i < NR; i++) begin
      a_v[i] = DW'(100 + i);
      b_v[i] = DW'(1000 * (i + 1));
    end
    n0 = rsp_cnt;
    req_valid = '1;
    for (int i = 0; i < 12; i++) step();
    req_valid = '0;
    drain();
    check("full_cnt", 64'(rsp_cnt - n0), 64'(12));

    // fairness between requesters 1 and 3
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1010;
    sample();
    check("fair_3", 64'(req_ready), 64'(4'b1000));
    adv();
    sample();
    check("fair_1", 64'(req_ready), 64'(4'b0010));
    adv();
    for (int i = 0; i < 4; i++) step();
    req_valid = '0;
    drain();

    // width edge
    a_v[0] = '1; b_v[0] = '1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    for (int i = 0; i < 3; i++) step();
    sample();
    check("wide", rsp_data, 64'hFFFF_FFFE_0000_0001);
    adv();
    drain();

    // reset with three ops in flight
    for (int i = 0; i < NR; i++) begin
      a_v[i] = DW'(i + 5);
      b_v[i] = DW'(i + 9);
    end
    n0 = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      req_valid = '0;
      req_valid[i] = 1'b1;
      step();
    end
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '1;
    sample();
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_ptr", 64'(req_ready), 64'(4'b0001));
    adv();
    req_valid = '0;
    drain();
    check("rst_cnt", 64'(rsp_cnt - n0), 64'(1));

    // sparse traffic with a long idle gap
    n0 = rsp_cnt;
    a_v[3] = 3; b_v[3] = 5;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("gap_a", 64'(mul_a), 64'd3);
      adv();
    end
    a_v[1] = 9; b_v[1] = 11;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    drain();
    check("sparse_cnt", 64'(rsp_cnt - n0), 64'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
- Shares one pipelined multiplier among NUM_REQ requesters using round-robin arbitration.
- Requesters use a valid/ready handshake; issue is one operand pair per cycle.
- Registers the winning operands onto the multiplier inputs and tracks the owner of each in-flight product with a tag pipeline.
- Returns each product to its owner as a one-hot response strobe. Sits between the conv-engine requesters and the Multiplier_2 instance.

Parameters:
- DATA_WIDTH, 32, operand width; products are 2*DATA_WIDTH.
- NUM_REQ, 4, number of requesters (2..8).
- MULT_LATENCY, 3, cycles from the multiplier input to the product appearing on mul_result.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*DATA_WIDTH  flattened operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  flattened operand B, same packing as req_a.
- mul_a  out  DATA_WIDTH  registered operand A to the multiplier.
- mul_b  out  DATA_WIDTH  registered operand B to the multiplier.
- mul_result  in  2*DATA_WIDTH  product from the multiplier.
- rsp_valid  out  NUM_REQ  one-hot product strobe.
- rsp_data  out  2*DATA_WIDTH  product; meaningful only while rsp_valid is nonzero.
- busy  out  1  high while any product is in flight.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, busy=0, rr pointer=0, tag pipeline cleared.
- Arbitration (combinational):
  - Search starts at the pointer index, increments modulo NUM_REQ, and takes the first asserted req_valid.
  - req_ready is asserted only for the winner. If no req_valid is set, req_ready=0.
  - req_ready is forced to 0 while rst=1.
- Handshake:
  - Transfer occurs in a cycle with req_valid[i] && req_ready[i].
  - A requester must hold req_a/req_b stable while valid is high and ready is low. Dropping valid without a transfer is legal and loses nothing.
- Pointer update: on a transfer by requester i, pointer <= (i+1) mod NUM_REQ. With no transfer the pointer holds. A requester that stays continuously valid is therefore granted at least once every NUM_REQ cycles.
- Issue:
  - On a transfer, mul_a/mul_b <= the winner's operands at the next edge.
  - With no transfer, mul_a/mul_b hold their previous values. The multiplier output is ignored in that case.
- Tag pipeline:
  - Shift register of depth MULT_LATENCY+1. Each entry is {valid, idx[clog2(NUM_REQ)-1:0]}.
  - Stage 0 is loaded with the transfer (valid=1, idx=winner) or valid=0. All stages shift every cycle.
- Response:
  - When the last stage is valid, rsp_valid = one-hot(idx) and rsp_data = mul_result (combinational pass-through).
  - When the last stage is invalid, rsp_valid=0 and rsp_data=0.
  - Latency: transfer in cycle t produces rsp_valid in cycle t+MULT_LATENCY+1 (t+4 with the default).
- Throughput: one transfer per cycle, with no bubbles.
- No back-pressure: the multiplier cannot stall, so a requester must accept its response in the cycle rsp_valid is asserted.
- busy = OR of all tag-stage valids. busy is low in the cycle after the final response leaves.
- Simultaneous events: a new transfer and a response for the same requester in the same cycle are both legal and independent.
- Reset mid-operation:
  - Every in-flight tag is discarded. No rsp_valid is asserted for operations issued before reset.
  - The multiplier's stale products are ignored.
  - The first post-reset transfer may happen in the first cycle with rst=0.
- Width: the product is the full 2*DATA_WIDTH unsigned value, with no truncation.

Test Plan:
- Single request: requester 2 offers a=7, b=6 at t=5 → req_ready[2] at t=5; rsp_valid=4'b0100 and rsp_data=42 at t=9; busy high t=6..9, low t=10.
- Full contention: all 4 valid continuously from t=0 with distinct operands → grants 0,1,2,3,0,… one per cycle; responses arrive in the same order 4 cycles later, each carrying the correct product.
- Pointer fairness: requesters 1 and 3 both valid, last grant was 1 → requester 3 granted next, then 1, alternating.
- Width edge: a=b=32'hFFFF_FFFF → rsp_data=64'hFFFF_FFFE_0000_0001.
- Reset mid-flight: issue three ops at t=0..2, assert rst at t=3 for one cycle → no rsp_valid for t≥3; busy=0 and pointer=0 after reset; a new op at t=4 returns at t=8.
- Sparse traffic with stalls: a valid request pulse of one cycle, a 10-cycle idle gap, then another request → mul_a/mul_b hold during the idle gap, and exactly two responses appear with the correct owners.
